axi_lite_ctrl_master: RTL and testbench
=======================================

# axi_lite_ctrl_master

AXI4-Lite initiator that converts single-word commands from a simple valid/ready command port into AXI-Lite write or read transactions and returns the response on a result port. It is the driving end of the 32-bit AXI-Lite control slave interface used by the RNG IP cores. It serves as the on-chip configuration sequencer and the bus-functional driver in block-level benches. One transaction is outstanding at a time. An optional watchdog guarantees the command port never hangs on an unresponsive slave.

## Interface
- ADDR_W, 4: AXI address width (byte address; slave decodes [3:2]).
- TIMEOUT, 255: watchdog limit in cycles (used only with AXI_CTRL_MASTER_TIMEOUT_EN); legal 1..65535.

- AXI_CTRL_ACLK  in  1  single clock, all logic on rising edge.
- AXI_CTRL_ARESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when both high.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  byte address.
- CMD_WDATA  in  32  write data.
- CMD_WSTRB  in  4  write byte strobes.
- RSP_VALID  out  1  result present.
- RSP_READY  in  1  result consumed when both high.
- RSP_RDATA  out  32  read data (0 for writes).
- RSP_RESP  out  2  BRESP/RRESP as returned.
- RSP_TIMEOUT  out  1  watchdog expired for this command.
- AXI_CTRL_AWADDR/AWPROT/AWVALID  out  ADDR_W/3/1; AWREADY in 1.
- AXI_CTRL_WDATA/WSTRB/WVALID  out  32/4/1; WREADY in 1.
- AXI_CTRL_BRESP in 2, BVALID in 1; BREADY out 1.
- AXI_CTRL_ARADDR/ARPROT/ARVALID  out  ADDR_W/3/1; ARREADY in 1.
- AXI_CTRL_RDATA in 32, RRESP in 2, RVALID in 1; RREADY out 1.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE: CMD_READY=1. CMD_VALID captures addr/data/strb/write into registers.
  - A write goes to WADDR with AWVALID=WVALID=1.
  - A read goes to RADDR with ARVALID=1.
- WADDR: AWVALID drops on the cycle after AWREADY is sampled high, and WVALID likewise on WREADY, independently. The FSM leaves for WRESP when both handshakes are complete, including when both complete in the same cycle. BREADY=0 in this state; an early BVALID is ignored and is expected to be held by the slave.
- WRESP: BREADY=1. On BVALID, latch BRESP, set RSP_RDATA=0, go to DONE.
- RADDR: hold ARVALID until ARREADY, then go to RDATA.
- RDATA: RREADY=1. On RVALID, latch RDATA/RRESP, go to DONE.
- DONE: RSP_VALID=1 with stable payload until RSP_READY. On handshake, return to IDLE. A new command cannot be accepted in the same cycle.
- AWPROT=ARPROT=3'b000 constant. Address/data outputs hold their captured values while VALID is high.
- Reset (asserted at any time, including mid-transaction) forces IDLE immediately and clears the captured payload.
  - Reset values: all VALID/READY outputs 0, CMD_READY 0 during reset, RSP_* 0, address/data outputs 0.
  - After deassert, CMD_READY=1 from the first clock edge.

## Timing
- All outputs are registered; there are no combinational paths from any input to any output.
- Command accepted at edge N: AWVALID/WVALID (or ARVALID) are high in cycle N+1.
- Zero-wait slave (READY in N+1, BVALID/RVALID in N+2): RSP_VALID is high in cycle N+3. The minimum latency is 3 cycles.
- Each slave wait cycle adds exactly one cycle.
- Throughput: at most one command per 4 cycles.

## Configuration
- AXI_CTRL_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on command accept and increments every cycle in WADDR/WRESP/RADDR/RDATA.
  - When it reaches TIMEOUT, all AXI VALID/READY outputs drop on the next edge, the FSM goes to DONE, and RSP_TIMEOUT=1, RSP_RESP=2'b10, RSP_RDATA=0.
  - RSP_TIMEOUT clears on the RSP handshake.
  - Abandoning a transaction is a deliberate protocol violation, accepted for debug recovery.
- Not defined: no counter is built, RSP_TIMEOUT is tied to 0, and the master waits indefinitely.

## Test plan
- Write addr 0x4, data 0xDEADBEEF, strb 0xF, zero-wait slave, BRESP 0 -> AW/W valid in N+1, RSP_VALID in N+3, RSP_RESP=0, RSP_RDATA=0.
- Read addr 0xC, slave RDATA 0x12345678 with ARREADY delayed 2 cycles -> RSP_VALID in N+5, RSP_RDATA=0x12345678.
- AWREADY in N+1, WREADY in N+4 -> AWVALID low from N+2, WVALID held until N+4, one B handshake, exactly one slave write.
- RSP_READY held low 5 cycles -> RSP payload stable, CMD_READY=0 throughout, next command accepted only after the handshake.
- With AXI_CTRL_MASTER_TIMEOUT_EN and TIMEOUT=8, the slave never asserts ARREADY -> ARVALID drops, RSP_VALID in N+9, RSP_TIMEOUT=1, RSP_RESP=2'b10.
- Reset asserted in WADDR between edges -> AWVALID/WVALID go low immediately (asynchronously), CMD_READY=1 after release, and a following read completes normally.

Source files
------------

// File: rtl/axi_lite_ctrl_master_if.sv
`default_nettype none
// ============================================================================
// axi_lite_ctrl_master_if : command/result port plus 32-bit AXI4-Lite control bus
// Rev 1.0 : initial release
// ============================================================================
interface axi_lite_ctrl_master_if #(
  parameter int ADDR_W = 4
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WRITE;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [31:0]       CMD_WDATA;
  logic [3:0]        CMD_WSTRB;

  logic              RSP_VALID;
  logic              RSP_READY;
  logic [31:0]       RSP_RDATA;
  logic [1:0]        RSP_RESP;
  logic              RSP_TIMEOUT;

  logic [ADDR_W-1:0] AXI_CTRL_AWADDR;
  logic [2:0]        AXI_CTRL_AWPROT;
  logic              AXI_CTRL_AWVALID;
  logic              AXI_CTRL_AWREADY;
  logic [31:0]       AXI_CTRL_WDATA;
  logic [3:0]        AXI_CTRL_WSTRB;
  logic              AXI_CTRL_WVALID;
  logic              AXI_CTRL_WREADY;
  logic [1:0]        AXI_CTRL_BRESP;
  logic              AXI_CTRL_BVALID;
  logic              AXI_CTRL_BREADY;
  logic [ADDR_W-1:0] AXI_CTRL_ARADDR;
  logic [2:0]        AXI_CTRL_ARPROT;
  logic              AXI_CTRL_ARVALID;
  logic              AXI_CTRL_ARREADY;
  logic [31:0]       AXI_CTRL_RDATA;
  logic [1:0]        AXI_CTRL_RRESP;
  logic              AXI_CTRL_RVALID;
  logic              AXI_CTRL_RREADY;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
    input  AXI_CTRL_AWREADY, AXI_CTRL_WREADY, AXI_CTRL_BRESP, AXI_CTRL_BVALID,
    input  AXI_CTRL_ARREADY, AXI_CTRL_RDATA, AXI_CTRL_RRESP, AXI_CTRL_RVALID,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP, RSP_TIMEOUT,
    output AXI_CTRL_AWADDR, AXI_CTRL_AWPROT, AXI_CTRL_AWVALID,
    output AXI_CTRL_WDATA, AXI_CTRL_WSTRB, AXI_CTRL_WVALID, AXI_CTRL_BREADY,
    output AXI_CTRL_ARADDR, AXI_CTRL_ARPROT, AXI_CTRL_ARVALID, AXI_CTRL_RREADY
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
    output AXI_CTRL_AWREADY, AXI_CTRL_WREADY, AXI_CTRL_BRESP, AXI_CTRL_BVALID,
    output AXI_CTRL_ARREADY, AXI_CTRL_RDATA, AXI_CTRL_RRESP, AXI_CTRL_RVALID,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP, RSP_TIMEOUT,
    input  AXI_CTRL_AWADDR, AXI_CTRL_AWPROT, AXI_CTRL_AWVALID,
    input  AXI_CTRL_WDATA, AXI_CTRL_WSTRB, AXI_CTRL_WVALID, AXI_CTRL_BREADY,
    input  AXI_CTRL_ARADDR, AXI_CTRL_ARPROT, AXI_CTRL_ARVALID, AXI_CTRL_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_ctrl_master.sv
`default_nettype none
// ============================================================================
// axi_lite_ctrl_master : single-outstanding AXI4-Lite initiator, command in / result out.
// Optional watchdog: define AXI_CTRL_MASTER_TIMEOUT_EN.   Rev 1.0 : initial release
// ============================================================================
module axi_lite_ctrl_master #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input logic                    AXI_CTRL_ACLK,
  input logic                    AXI_CTRL_ARESET,
  axi_lite_ctrl_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_timeout_range_check
    $error("axi_lite_ctrl_master: TIMEOUT must lie in 1..65535");
  end

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;

`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
  localparam logic [16:0] c_TIMEOUT = 17'(TIMEOUT);
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        tmo_q, tmo_d;
`endif

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    case (state_q)
      S_IDLE: begin
        if (bus.CMD_VALID && cmd_ready_q) begin
          addr_d  = bus.CMD_ADDR;
          wdata_d = bus.CMD_WDATA;
          wstrb_d = bus.CMD_WSTRB;
          if (bus.CMD_WRITE) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        // AW and W retire independently; leave once neither is pending
        awvalid_d = awvalid_q && !bus.AXI_CTRL_AWREADY;
        wvalid_d  = wvalid_q && !bus.AXI_CTRL_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bus.AXI_CTRL_BVALID && bready_q) begin
          resp_d  = bus.AXI_CTRL_BRESP;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_RADDR: begin
        if (bus.AXI_CTRL_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (bus.AXI_CTRL_RVALID && rready_q) begin
          rdata_d = bus.AXI_CTRL_RDATA;
          resp_d  = bus.AXI_CTRL_RRESP;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.RSP_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    cnt_inc = {1'b0, cnt_q} + 17'd1;
    if (state_q == S_IDLE) begin
      if (bus.CMD_VALID && cmd_ready_q) begin
        cnt_d = '0;
      end
    end else if (state_q != S_DONE) begin
      cnt_d = cnt_inc[15:0];
      // A response arriving on the expiry cycle still wins over the abandon
      if ((cnt_inc >= c_TIMEOUT) && (state_d != S_DONE)) begin
        state_d   = S_DONE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        rdata_d   = '0;
        resp_d    = 2'b10;
        tmo_d     = 1'b1;
      end
    end else if (bus.RSP_READY) begin
      tmo_d = 1'b0;
    end
`endif

    bready_d    = (state_d == S_WRESP);
    rready_d    = (state_d == S_RDATA);
    rsp_valid_d = (state_d == S_DONE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge AXI_CTRL_ACLK or posedge AXI_CTRL_ARESET) begin
    if (AXI_CTRL_ARESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
  always_ff @(posedge AXI_CTRL_ACLK or posedge AXI_CTRL_ARESET) begin
    if (AXI_CTRL_ARESET) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.RSP_TIMEOUT = tmo_q;
`else
  assign bus.RSP_TIMEOUT = 1'b0;
`endif

  assign bus.CMD_READY        = cmd_ready_q;
  assign bus.RSP_VALID        = rsp_valid_q;
  assign bus.RSP_RDATA        = rdata_q;
  assign bus.RSP_RESP         = resp_q;
  assign bus.AXI_CTRL_AWADDR  = addr_q;
  assign bus.AXI_CTRL_AWPROT  = 3'b000;
  assign bus.AXI_CTRL_AWVALID = awvalid_q;
  assign bus.AXI_CTRL_WDATA   = wdata_q;
  assign bus.AXI_CTRL_WSTRB   = wstrb_q;
  assign bus.AXI_CTRL_WVALID  = wvalid_q;
  assign bus.AXI_CTRL_BREADY  = bready_q;
  assign bus.AXI_CTRL_ARADDR  = addr_q;
  assign bus.AXI_CTRL_ARPROT  = 3'b000;
  assign bus.AXI_CTRL_ARVALID = arvalid_q;
  assign bus.AXI_CTRL_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_ctrl_master.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_ctrl_master : randomized bench with a behavioural AXI-Lite slave and memory model.
// Rev 1.0 : initial release
// ============================================================================
module tb_axi_lite_ctrl_master;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  typedef struct {
    bit          write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    int          hold;
  } cmd_t;

  typedef struct {
    int          acc_wait, lat;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    int          aw_cyc, w_cyc, ar_cyc;
    logic        aw_first, w_first, ar_first;
    int          busy_rdy, unstable, writes;
    logic        after_valid, after_ready, after_tmo;
  } obs_t;

  axi_lite_ctrl_master_if #(.ADDR_W(ADDR_W)) bus ();

  axi_lite_ctrl_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .AXI_CTRL_ACLK   (clk),
    .AXI_CTRL_ARESET (rst),
    .bus             (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural slave ----------------
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  s_resp;
  logic [31:0] s_mem [4];
  int          wr_count;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, b_pend, r_pend;
  logic [3:0]  aw_addr_s, ar_addr_s;
  logic [31:0] w_data_s;
  logic [3:0]  w_strb_s;

  // reference memory: what the slave should hold after each completed write
  logic [31:0] mem_model [4];

  task automatic slave_clear();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    bus.AXI_CTRL_AWREADY = 0; bus.AXI_CTRL_WREADY = 0;
    bus.AXI_CTRL_BVALID = 0;  bus.AXI_CTRL_BRESP = 0;
    bus.AXI_CTRL_ARREADY = 0; bus.AXI_CTRL_RVALID = 0;
    bus.AXI_CTRL_RDATA = 0;   bus.AXI_CTRL_RRESP = 0;
  endtask

  // Runs each falling edge; a handshake flagged here completes on the next rising edge.
  task automatic slave_step();
    if (aw_hs) begin bus.AXI_CTRL_AWREADY = 0; aw_hs = 0; aw_got = 1; end
    if (w_hs)  begin bus.AXI_CTRL_WREADY = 0;  w_hs = 0;  w_got = 1;  end
    if (b_hs)  begin bus.AXI_CTRL_BVALID = 0;  b_hs = 0; end
    if (ar_hs) begin bus.AXI_CTRL_ARREADY = 0; ar_hs = 0; r_pend = 1; r_cnt = 0; ar_cnt = 0; end
    if (r_hs)  begin bus.AXI_CTRL_RVALID = 0;  r_hs = 0; end

    if (bus.AXI_CTRL_AWVALID && !aw_got && !bus.AXI_CTRL_AWREADY) begin
      if (aw_cnt >= aw_dly) begin bus.AXI_CTRL_AWREADY = 1; aw_addr_s = bus.AXI_CTRL_AWADDR; end
      else aw_cnt++;
    end
    if (bus.AXI_CTRL_AWVALID && bus.AXI_CTRL_AWREADY) aw_hs = 1;
    if (bus.AXI_CTRL_WVALID && !w_got && !bus.AXI_CTRL_WREADY) begin
      if (w_cnt >= w_dly) begin
        bus.AXI_CTRL_WREADY = 1; w_data_s = bus.AXI_CTRL_WDATA; w_strb_s = bus.AXI_CTRL_WSTRB;
      end else w_cnt++;
    end
    if (bus.AXI_CTRL_WVALID && bus.AXI_CTRL_WREADY) w_hs = 1;

    if (aw_got && w_got) begin
      for (int i = 0; i < 4; i++)
        if (w_strb_s[i]) s_mem[aw_addr_s[3:2]][8*i +: 8] = w_data_s[8*i +: 8];
      wr_count++;
      aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_pend = 1; b_cnt = 0;
    end
    if (b_pend) begin
      if (b_cnt >= b_dly) begin bus.AXI_CTRL_BVALID = 1; bus.AXI_CTRL_BRESP = s_resp; b_pend = 0; end
      else b_cnt++;
    end
    if (bus.AXI_CTRL_BVALID && bus.AXI_CTRL_BREADY) b_hs = 1;

    if (bus.AXI_CTRL_ARVALID && !bus.AXI_CTRL_ARREADY && !r_pend && !bus.AXI_CTRL_RVALID) begin
      if (ar_cnt >= ar_dly) begin bus.AXI_CTRL_ARREADY = 1; ar_addr_s = bus.AXI_CTRL_ARADDR; end
      else ar_cnt++;
    end
    if (bus.AXI_CTRL_ARVALID && bus.AXI_CTRL_ARREADY) ar_hs = 1;
    if (r_pend) begin
      if (r_cnt >= r_dly) begin
        bus.AXI_CTRL_RVALID = 1; bus.AXI_CTRL_RDATA = s_mem[ar_addr_s[3:2]];
        bus.AXI_CTRL_RRESP = s_resp; r_pend = 0;
      end else r_cnt++;
    end
    if (bus.AXI_CTRL_RVALID && bus.AXI_CTRL_RREADY) r_hs = 1;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst) slave_step();
    end
  end

  // ---------------- command driver / observer (called at a falling edge) ----------------
  task automatic run_cmd(input cmd_t c, output obs_t o);
    logic [35:0] snap;
    int base_wr;
    o = '{default: 0};
    aw_dly = c.aw_d; w_dly = c.w_d; b_dly = c.b_d; ar_dly = c.ar_d; r_dly = c.r_d; s_resp = c.resp;
    base_wr = wr_count;
    bus.CMD_VALID = 1; bus.CMD_WRITE = c.write; bus.CMD_ADDR = c.addr;
    bus.CMD_WDATA = c.wdata; bus.CMD_WSTRB = c.wstrb;
    while (!bus.CMD_READY && o.acc_wait < 50) begin @(negedge clk); o.acc_wait++; end
    @(posedge clk); #1;
    bus.CMD_VALID = 0;
    o.lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        o.aw_first = bus.AXI_CTRL_AWVALID; o.w_first = bus.AXI_CTRL_WVALID; o.ar_first = bus.AXI_CTRL_ARVALID;
      end
      if (bus.AXI_CTRL_AWVALID) o.aw_cyc++;
      if (bus.AXI_CTRL_WVALID)  o.w_cyc++;
      if (bus.AXI_CTRL_ARVALID) o.ar_cyc++;
      if (bus.CMD_READY) o.busy_rdy++;
      if (bus.RSP_VALID) begin o.lat = k; break; end
    end
    o.rdata = bus.RSP_RDATA; o.resp = bus.RSP_RESP; o.tmo = bus.RSP_TIMEOUT;
    snap = {bus.RSP_VALID, bus.RSP_TIMEOUT, bus.RSP_RESP, bus.RSP_RDATA};
    for (int h = 0; h < c.hold; h++) begin
      bus.RSP_READY = 0;
      @(negedge clk);
      if ({bus.RSP_VALID, bus.RSP_TIMEOUT, bus.RSP_RESP, bus.RSP_RDATA} !== snap) o.unstable++;
      if (bus.CMD_READY) o.busy_rdy++;
    end
    bus.RSP_READY = 1;
    @(posedge clk); #1;
    bus.RSP_READY = 0;
    @(negedge clk);
    o.after_valid = bus.RSP_VALID; o.after_ready = bus.CMD_READY; o.after_tmo = bus.RSP_TIMEOUT;
    o.writes = wr_count - base_wr;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({bus.CMD_READY, bus.RSP_VALID, bus.AXI_CTRL_AWVALID, bus.AXI_CTRL_WVALID, bus.AXI_CTRL_BREADY,
         bus.AXI_CTRL_ARVALID, bus.AXI_CTRL_RREADY, bus.RSP_TIMEOUT} !== 8'h00) begin
      miscompares++; $display("FAIL reset_handshake_outputs: got %b required 00000000",
        {bus.CMD_READY, bus.RSP_VALID, bus.AXI_CTRL_AWVALID, bus.AXI_CTRL_WVALID, bus.AXI_CTRL_BREADY,
         bus.AXI_CTRL_ARVALID, bus.AXI_CTRL_RREADY, bus.RSP_TIMEOUT});
    end
    vectors++;
    if ({bus.RSP_RDATA, bus.RSP_RESP, bus.AXI_CTRL_AWADDR, bus.AXI_CTRL_ARADDR, bus.AXI_CTRL_WDATA,
         bus.AXI_CTRL_WSTRB, bus.AXI_CTRL_AWPROT, bus.AXI_CTRL_ARPROT} !== '0) begin
      miscompares++; $display("FAIL reset_payload: rdata %h resp %h addr %h wdata %h required all zero",
        bus.RSP_RDATA, bus.RSP_RESP, bus.AXI_CTRL_AWADDR, bus.AXI_CTRL_WDATA);
    end
    rst = 0;
    @(posedge clk); #1;
    vectors++;
    if (bus.CMD_READY !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_cmd_ready: got %b required 1", bus.CMD_READY);
    end
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    cmd_t c; obs_t o;
    c = '{write: 1, addr: 4'h4, wdata: 32'hDEADBEEF, wstrb: 4'hF, resp: 2'b00, default: 0};
    run_cmd(c, o);
    mem_model[1] = merge(mem_model[1], c.wdata, c.wstrb);
    vectors++; if (o.lat !== 3) begin miscompares++; $display("FAIL wr_basic_latency: got %0d required 3", o.lat); end
    vectors++; if ({o.aw_first, o.w_first} !== 2'b11) begin miscompares++; $display("FAIL wr_basic_valid_n1: got %b required 11", {o.aw_first, o.w_first}); end
    vectors++; if (o.resp !== 2'b00) begin miscompares++; $display("FAIL wr_basic_resp: got %0d required 0", o.resp); end
    vectors++; if (o.rdata !== 32'h0) begin miscompares++; $display("FAIL wr_basic_rdata: got %h required 0", o.rdata); end
    vectors++; if (s_mem[1] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_basic_slave_word: got %h required deadbeef", s_mem[1]); end
  endtask

  task automatic test_read_delayed();
    cmd_t c; obs_t o;
    s_mem[3] = 32'h12345678; mem_model[3] = 32'h12345678;
    c = '{write: 0, addr: 4'hC, ar_d: 2, resp: 2'b00, default: 0};
    run_cmd(c, o);
    vectors++; if (o.lat !== 5) begin miscompares++; $display("FAIL rd_delay_latency: got %0d required 5", o.lat); end
    vectors++; if (o.rdata !== 32'h12345678) begin miscompares++; $display("FAIL rd_delay_rdata: got %h required 12345678", o.rdata); end
    vectors++; if (o.ar_cyc !== 3) begin miscompares++; $display("FAIL rd_delay_arvalid_cycles: got %0d required 3", o.ar_cyc); end
  endtask

  task automatic test_split_handshake();
    cmd_t c; obs_t o;
    c = '{write: 1, addr: 4'h8, wdata: 32'hA5A5_0F0F, wstrb: 4'hF, aw_d: 0, w_d: 3, resp: 2'b00, default: 0};
    run_cmd(c, o);
    mem_model[2] = merge(mem_model[2], c.wdata, c.wstrb);
    vectors++; if (o.aw_cyc !== 1) begin miscompares++; $display("FAIL split_awvalid_cycles: got %0d required 1", o.aw_cyc); end
    vectors++; if (o.w_cyc !== 4) begin miscompares++; $display("FAIL split_wvalid_cycles: got %0d required 4", o.w_cyc); end
    vectors++; if (o.writes !== 1) begin miscompares++; $display("FAIL split_slave_writes: got %0d required 1", o.writes); end
    vectors++; if (o.lat !== 6) begin miscompares++; $display("FAIL split_latency: got %0d required 6", o.lat); end
  endtask

  task automatic test_rsp_backpressure();
    cmd_t c; obs_t o;
    c = '{write: 0, addr: 4'h8, resp: 2'b01, hold: 5, default: 0};
    run_cmd(c, o);
    vectors++; if (o.unstable !== 0) begin miscompares++; $display("FAIL bp_payload_stable: got %0d changes required 0", o.unstable); end
    vectors++; if (o.busy_rdy !== 0) begin miscompares++; $display("FAIL bp_cmd_ready_busy: got %0d cycles high required 0", o.busy_rdy); end
    vectors++; if (o.rdata !== mem_model[2] || o.resp !== 2'b01) begin miscompares++; $display("FAIL bp_result: got %h/%0d required %h/1", o.rdata, o.resp, mem_model[2]); end
    vectors++; if ({o.after_valid, o.after_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_after_handshake: got %b required 01", {o.after_valid, o.after_ready}); end
  endtask

  task automatic test_back_to_back();
    cmd_t c; obs_t o1, o2;
    c = '{write: 1, addr: 4'h0, wdata: 32'h0BAD_F00D, wstrb: 4'h5, resp: 2'b00, default: 0};
    run_cmd(c, o1);
    mem_model[0] = merge(mem_model[0], c.wdata, c.wstrb);
    c = '{write: 0, addr: 4'h0, resp: 2'b00, default: 0};
    run_cmd(c, o2);
    // accept-to-accept distance = lat1 + 1 + acc_wait2; four cycles at best
    vectors++; if (o1.lat + 1 + o2.acc_wait !== 4) begin miscompares++; $display("FAIL b2b_accept_spacing: got %0d required 4", o1.lat + 1 + o2.acc_wait); end
    vectors++; if (o2.rdata !== mem_model[0]) begin miscompares++; $display("FAIL b2b_readback: got %h required %h", o2.rdata, mem_model[0]); end
  endtask

`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    cmd_t c; obs_t o;
    c = '{write: 0, addr: 4'h4, ar_d: 100000, resp: 2'b00, default: 0};
    run_cmd(c, o);
    slave_clear();
    vectors++; if (o.lat !== TIMEOUT + 1) begin miscompares++; $display("FAIL tmo_latency: got %0d required %0d", o.lat, TIMEOUT + 1); end
    vectors++; if ({o.tmo, o.resp} !== 3'b110) begin miscompares++; $display("FAIL tmo_flags: got %b required 110", {o.tmo, o.resp}); end
    vectors++; if (o.rdata !== 32'h0) begin miscompares++; $display("FAIL tmo_rdata: got %h required 0", o.rdata); end
    vectors++; if (o.ar_cyc !== TIMEOUT) begin miscompares++; $display("FAIL tmo_arvalid_cycles: got %0d required %0d", o.ar_cyc, TIMEOUT); end
    vectors++; if (o.after_tmo !== 1'b0) begin miscompares++; $display("FAIL tmo_clear: got %b required 0", o.after_tmo); end
  endtask
`endif

  task automatic test_random();
    cmd_t c; obs_t o;
    int exp_lat;
    logic [31:0] exp_rdata;
    for (int n = 0; n < 40; n++) begin
      c.write = 1'($urandom_range(0, 1));
      c.addr  = 4'($urandom_range(0, 15));
      c.wdata = $urandom;
      c.wstrb = 4'($urandom_range(0, 15));
      c.aw_d = $urandom_range(0, 2); c.w_d = $urandom_range(0, 2); c.b_d = $urandom_range(0, 2);
      c.ar_d = $urandom_range(0, 2); c.r_d = $urandom_range(0, 2);
      c.resp = 2'($urandom_range(0, 3));
      c.hold = $urandom_range(0, 3);
      exp_lat   = c.write ? 3 + imax(c.aw_d, c.w_d) + c.b_d : 3 + c.ar_d + c.r_d;
      exp_rdata = c.write ? 32'h0 : mem_model[c.addr[3:2]];
      run_cmd(c, o);
      if (c.write) mem_model[c.addr[3:2]] = merge(mem_model[c.addr[3:2]], c.wdata, c.wstrb);
      vectors++; if (o.lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d required %0d", n, o.lat, exp_lat); end
      vectors++; if (o.rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd%0d_rdata: got %h required %h", n, o.rdata, exp_rdata); end
      vectors++; if ({o.tmo, o.resp} !== {1'b0, c.resp}) begin miscompares++; $display("FAIL rnd%0d_resp: got %b required %b", n, {o.tmo, o.resp}, {1'b0, c.resp}); end
      vectors++;
      if ({o.aw_cyc, o.w_cyc, o.ar_cyc, o.writes} !== (c.write ? {1 + c.aw_d, 1 + c.w_d, 0, 1} : {0, 0, 1 + c.ar_d, 0})) begin
        miscompares++; $display("FAIL rnd%0d_channels: aw %0d w %0d ar %0d writes %0d (write=%0d aw_d %0d w_d %0d ar_d %0d)",
          n, o.aw_cyc, o.w_cyc, o.ar_cyc, o.writes, c.write, c.aw_d, c.w_d, c.ar_d);
      end
      vectors++; if (o.busy_rdy !== 0 || o.unstable !== 0) begin miscompares++; $display("FAIL rnd%0d_busy: cmd_ready %0d unstable %0d required 0/0", n, o.busy_rdy, o.unstable); end
    end
  endtask

  task automatic test_reset_mid_write();
    cmd_t c; obs_t o;
    aw_dly = 6; w_dly = 6; s_resp = 0;
    bus.CMD_VALID = 1; bus.CMD_WRITE = 1; bus.CMD_ADDR = 4'h4; bus.CMD_WDATA = 32'hFFFF_FFFF; bus.CMD_WSTRB = 4'hF;
    @(posedge clk); #1;
    bus.CMD_VALID = 0;
    @(negedge clk);
    vectors++; if ({bus.AXI_CTRL_AWVALID, bus.AXI_CTRL_WVALID} !== 2'b11) begin miscompares++; $display("FAIL rstmid_in_waddr: got %b required 11", {bus.AXI_CTRL_AWVALID, bus.AXI_CTRL_WVALID}); end
    #2 rst = 1;
    #1;
    vectors++; if ({bus.AXI_CTRL_AWVALID, bus.AXI_CTRL_WVALID, bus.CMD_READY} !== 3'b000) begin miscompares++; $display("FAIL rstmid_async_clear: got %b required 000", {bus.AXI_CTRL_AWVALID, bus.AXI_CTRL_WVALID, bus.CMD_READY}); end
    @(negedge clk);
    #2 rst = 0;
    slave_clear();
    @(posedge clk); #1;
    vectors++; if (bus.CMD_READY !== 1'b1) begin miscompares++; $display("FAIL rstmid_cmd_ready: got %b required 1", bus.CMD_READY); end
    @(negedge clk);
    c = '{write: 0, addr: 4'h4, resp: 2'b00, default: 0};
    run_cmd(c, o);
    vectors++; if (o.lat !== 3 || o.rdata !== mem_model[1]) begin miscompares++; $display("FAIL rstmid_followup_read: got lat %0d data %h required 3/%h", o.lat, o.rdata, mem_model[1]); end
  endtask

  initial begin
    vectors = 0; miscompares = 0; wr_count = 0;
    rst = 1;
    bus.CMD_VALID = 0; bus.CMD_WRITE = 0; bus.CMD_ADDR = 0; bus.CMD_WDATA = 0; bus.CMD_WSTRB = 0;
    bus.RSP_READY = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; s_resp = 0;
    for (int i = 0; i < 4; i++) begin s_mem[i] = 0; mem_model[i] = 0; end
    repeat (2) @(negedge clk);
    test_reset();
    test_write_basic();
    test_read_delayed();
    test_split_handshake();
    test_rsp_backpressure();
    test_back_to_back();
`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
